// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the CPU's single memory port between the instruction-fetch (I)
//   requester and the load/store (D) requester. A three-state FSM serialises
//   the two requesters. Under contention it alternates grants so that neither
//   side starves. All mem_* outputs are registered. Acknowledges and read data
//   are combinational from mem_ack, so the winning requester sees the ack in
//   the same cycle as mem_ack.
//
//   Optional feature: define MEM_ARB_TIMEOUT_EN to enable a busy-cycle
//   watchdog. The watchdog aborts a transfer that sees no mem_ack for
//   TIMEOUT_CYC cycles and signals bus_err.
//
//   Ports:
//     clk, reset_n      clock (rising edge), asynchronous active-low reset
//     i_req/i_addr      fetch request and address
//     i_ack/i_rdata     fetch completion pulse and instruction word
//     d_req/d_we/d_be   load/store request, write enable, byte enables
//     d_addr/d_wdata    load/store address and store data
//     d_ack/d_rdata     load/store completion pulse and load data
//     stall             a requester is waiting for its ack
//     bus_err           pulses with the ack of an aborted transfer
//     mem_req/we/be     registered memory request, write enable, byte enables
//     mem_addr/wdata    registered memory address and write data
//     mem_ack/mem_rdata memory completion pulse and read data
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                stall,
  output logic                bus_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_owner_q, last_owner_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic busy;
  logic timeout_hit;
  logic done;

  assign busy = (state_q != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  // The watchdog counter is at least 8 bits wide and wide enough to hold TIMEOUT_CYC.
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A mem_ack in the timeout cycle takes priority, so that transfer completes normally.
  assign timeout_hit = busy && !mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYC));
  assign bus_err     = timeout_hit;

  // The counter is held at zero while IDLE, so every grant starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!busy) begin
      cnt_d = '0;
    end else if (!mem_ack && !timeout_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  assign done = busy && (mem_ack || timeout_hit);

  // Only the current owner is acknowledged. Read data is zero for stores and for aborts.
  assign i_ack   = (state_q == BUSY_I) && done;
  assign d_ack   = (state_q == BUSY_D) && done;
  assign i_rdata = (i_ack && mem_ack) ? mem_rdata : '0;
  assign d_rdata = (d_ack && mem_ack && !mem_we_q) ? mem_rdata : '0;

  // Gating stall with reset_n keeps the pipeline from freezing while the
  // arbiter is held in reset.
  assign stall = reset_n & ((i_req & ~i_ack) | (d_req & ~d_ack));

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state logic. On contention, D wins if I owned the port last, and I wins otherwise.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (d_req && (!i_req || last_owner_q == OWNER_I)) begin
          state_d      = BUSY_D;
          last_owner_d = OWNER_D;
          mem_req_d    = 1'b1;
          mem_we_d     = d_we;
          mem_be_d     = d_be;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
        end else if (i_req) begin
          state_d      = BUSY_I;
          last_owner_d = OWNER_I;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_be_d     = '0;
          mem_addr_d   = i_addr;
          mem_wdata_d  = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_I;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. A scoreboard queue holds the expected
// owner and read data of each completion. An entry is pushed when the bench
// drives mem_ack and popped when the DUT acknowledges a requester.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        stall;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        owner_d;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests_run;
  int   tests_failed;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .stall(stall), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are changed at the falling edge, and outputs are sampled 1 ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_mem_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      #1;
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0040;
    step(); #1;
    tests_run++;
    if (mem_req !== 1'b0 || i_ack !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: mem_req=%b i_ack=%b stall=%b, want 0 0 0", mem_req, i_ack, stall);
    end
    tests_run++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0 || bus_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: i_rdata=%h d_rdata=%h bus_err=%b, want 0", i_rdata, d_rdata, bus_err);
    end
    reset_n = 1'b1;
    step(); #1;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0040 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_grant: mem_req=%b mem_addr=%h mem_we=%b, want 1 00000040 0", mem_req, mem_addr, mem_we);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    sb.push_back('{owner_d: 1'b0, rdata: 32'h1111_2222});
    #1;
    tests_run++;
    if (i_ack !== 1'b1 || sb.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_ack: i_ack=%b, want 1", i_ack);
    end else begin
      e = sb.pop_front();
      if (i_rdata !== e.rdata || d_ack !== e.owner_d) begin
        tests_failed++;
        $display("[TB] FAIL reset_first_rdata: i_rdata=%h d_ack=%b, want %h 0", i_rdata, d_ack, e.rdata);
      end
    end
    step();
    mem_ack = 1'b0; i_req = 1'b0;
    #1;
  endtask

  task automatic test_single_fetch();
    i_req = 1'b1; i_addr = 32'h0000_0010;
    step(); #1;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0010 || mem_we !== 1'b0 || mem_be !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL fetch_grant: mem_req=%b addr=%h we=%b be=%b, want 1 00000010 0 0000", mem_req, mem_addr, mem_we, mem_be);
    end
    for (int k = 0; k < 2; k++) begin
      step(); #1;
      tests_run++;
      if (mem_req !== 1'b1 || i_ack !== 1'b0 || stall !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL fetch_wait: mem_req=%b i_ack=%b stall=%b, want 1 0 1", mem_req, i_ack, stall);
      end
    end
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    sb.push_back('{owner_d: 1'b0, rdata: 32'h0050_0093});
    #1;
    tests_run++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0 || stall !== 1'b0 || sb.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL fetch_ack: i_ack=%b d_ack=%b stall=%b, want 1 0 0", i_ack, d_ack, stall);
    end else begin
      e = sb.pop_front();
      if (i_rdata !== e.rdata) begin
        tests_failed++;
        $display("[TB] FAIL fetch_rdata: i_rdata=%h, want %h", i_rdata, e.rdata);
      end
    end
    step();
    mem_ack = 1'b0; i_req = 1'b0;
    #1;
    tests_run++;
    if (i_ack !== 1'b0 || mem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fetch_pulse_end: i_ack=%b mem_req=%b, want 0 0", i_ack, mem_req);
    end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
    step(); #1;
    tests_run++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 ||
        mem_addr !== 32'h0000_0100 || mem_wdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("[TB] FAIL store_grant: req=%b we=%b be=%b addr=%h wdata=%h, want 1 1 0011 00000100 deadbeef",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    step();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    sb.push_back('{owner_d: 1'b1, rdata: 32'h0});
    #1;
    tests_run++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0 || bus_err !== 1'b0 || sb.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL store_ack: d_ack=%b i_ack=%b bus_err=%b, want 1 0 0", d_ack, i_ack, bus_err);
    end else begin
      e = sb.pop_front();
      if (d_rdata !== e.rdata) begin
        tests_failed++;
        $display("[TB] FAIL store_rdata: d_rdata=%h, want %h", d_rdata, e.rdata);
      end
    end
    step();
    mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    #1;
  endtask

  task automatic test_contention();
    bit          ok;
    logic        want_d;
    logic [31:0] want_addr;
    logic [31:0] rd;
    reset_n = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    step();
    reset_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      want_d    = (t % 2 == 0);
      want_addr = want_d ? 32'h0000_0300 : 32'h0000_0200;
      wait_mem_req(5, ok);
      tests_run++;
      if (!ok || mem_addr !== want_addr) begin
        tests_failed++;
        $display("[TB] FAIL contention_order[%0d]: granted=%b mem_addr=%h, want %h", t, ok, mem_addr, want_addr);
      end
      step();
      rd = 32'hA000_0000 + 32'(t);
      mem_ack = 1'b1; mem_rdata = rd;
      sb.push_back('{owner_d: want_d, rdata: rd});
      #1;
      e = sb.pop_front();
      tests_run++;
      if (d_ack !== e.owner_d || i_ack !== !e.owner_d ||
          (e.owner_d ? d_rdata : i_rdata) !== e.rdata) begin
        tests_failed++;
        $display("[TB] FAIL contention_ack[%0d]: i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h, want owner_d=%b rdata=%h",
                 t, i_ack, d_ack, i_rdata, d_rdata, e.owner_d, e.rdata);
      end
      step();
      mem_ack = 1'b0;
      #1;
      tests_run++;
      if (mem_req !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL contention_idle_gap[%0d]: mem_req=%b, want 0", t, mem_req);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
    #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
    wait_mem_req(5, ok);
    tests_run++;
    if (!ok || mem_addr !== 32'h0000_0500) begin
      tests_failed++;
      $display("[TB] FAIL resetmid_grant: granted=%b mem_addr=%h, want 00000500", ok, mem_addr);
    end
    step(); step();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || d_ack !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL resetmid_clear: mem_req=%b d_ack=%b stall=%b, want 0 0 0", mem_req, d_ack, stall);
    end
    step();
    reset_n = 1'b1;
    step(); #1;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0500 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL resetmid_regrant: mem_req=%b mem_addr=%h mem_we=%b, want 1 00000500 0", mem_req, mem_addr, mem_we);
    end
    step();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    sb.push_back('{owner_d: 1'b1, rdata: 32'hCAFE_0001});
    #1;
    e = sb.pop_front();
    tests_run++;
    if (d_ack !== 1'b1 || d_rdata !== e.rdata) begin
      tests_failed++;
      $display("[TB] FAIL resetmid_ack: d_ack=%b d_rdata=%h, want 1 %h", d_ack, d_rdata, e.rdata);
    end
    step();
    mem_ack = 1'b0; d_req = 1'b0;
    #1;
  endtask

  task automatic test_req_drop();
    bit ok;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0700;
    wait_mem_req(5, ok);
    d_req = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h7777_0007;
    sb.push_back('{owner_d: 1'b1, rdata: 32'h7777_0007});
    #1;
    e = sb.pop_front();
    tests_run++;
    if (!ok || d_ack !== 1'b1 || d_rdata !== e.rdata) begin
      tests_failed++;
      $display("[TB] FAIL req_drop_ack: granted=%b d_ack=%b d_rdata=%h, want 1 1 %h", ok, d_ack, d_rdata, e.rdata);
    end
    step();
    mem_ack = 1'b0;
    #1;
  endtask

  task automatic test_mem_ack_idle();
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    tests_run++;
    if (i_ack !== 1'b0 || d_ack !== 1'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL idle_ack_ignored: i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h, want 0", i_ack, d_ack, i_rdata, d_rdata);
    end
    step();
    mem_ack = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_no_req: mem_req=%b, want 0", mem_req);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    i_req = 1'b1; i_addr = 32'h0000_0600;
    wait_mem_req(5, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL timeout_grant: mem_req=%b, want 1", mem_req);
    end
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 1; k < 9; k++) begin
      tests_run++;
      if (i_ack !== 1'b0 || bus_err !== 1'b0 || mem_req !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL timeout_early[%0d]: i_ack=%b bus_err=%b mem_req=%b, want 0 0 1", k, i_ack, bus_err, mem_req);
      end
      step(); #1;
    end
    tests_run++;
    if (i_ack !== 1'b1 || bus_err !== 1'b1 || i_rdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_abort: i_ack=%b bus_err=%b i_rdata=%h, want 1 1 0", i_ack, bus_err, i_rdata);
    end
    step();
    i_req = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || i_ack !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_idle: mem_req=%b i_ack=%b, want 0 0", mem_req, i_ack);
    end
`else
    for (int k = 0; k < 50; k++) begin
      step();
    end
    #1;
    tests_run++;
    if (mem_req !== 1'b1 || i_ack !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL no_timeout_busy: mem_req=%b i_ack=%b bus_err=%b stall=%b, want 1 0 0 1",
               mem_req, i_ack, bus_err, stall);
    end
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    sb.push_back('{owner_d: 1'b0, rdata: 32'h0BAD_F00D});
    #1;
    e = sb.pop_front();
    tests_run++;
    if (i_ack !== 1'b1 || i_rdata !== e.rdata || bus_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL no_timeout_late_ack: i_ack=%b i_rdata=%h bus_err=%b, want 1 %h 0", i_ack, i_rdata, bus_err, e.rdata);
    end
    step();
    mem_ack = 1'b0; i_req = 1'b0;
    #1;
`endif
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_reset_mid();
    test_req_drop();
    test_mem_ack_idle();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between the instruction-fetch (I) requester and the load/store (D) requester of the datapath.
- Sits between the datapath and the unified instruction/data memory.
- Serialises requests through a small FSM and registers the memory-side signals.
- Returns a one-cycle acknowledge to the winning requester and stalls the other.

Parameters:
ADDR_W, 32, address width of both requesters and of the memory port
DATA_W, 32, data width; DATA_W/8 byte enables
TIMEOUT_CYC, 255, cycles without mem_ack before abort (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
i_req  in  1  fetch request, held until i_ack
i_addr  in  ADDR_W  fetch address, stable while i_req
i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  out  DATA_W  fetched instruction word
d_req  in  1  load/store request, held until d_ack
d_we  in  1  1 = store, 0 = load
d_be  in  DATA_W/8  byte enables for store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse: access complete
d_rdata  out  DATA_W  load data, valid with d_ack
stall  out  1  (i_req & ~i_ack) | (d_req & ~d_ack)
bus_err  out  1  pulse with ack on aborted transfer
mem_req  out  1  memory request, registered
mem_we  out  1  registered write enable
mem_be  out  DATA_W/8  registered byte enables
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_ack  in  1  memory completion pulse
mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- Reset state:
  - FSM in IDLE; last_owner = I.
  - All mem_* outputs, acks and bus_err are 0.
  - i_rdata and d_rdata are 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Samples requests each cycle.
  - Only d_req: go to BUSY_D.
  - Only i_req: go to BUSY_I.
  - Both: grant the owner that did not win last grant. last_owner = I grants D; last_owner = D grants I. This alternates under contention and prevents starvation.
  - On grant, register the owner's addr/we/be/wdata into mem_*, set mem_req = 1, and update last_owner.
  - An I grant forces mem_we = 0 and mem_be = 0.
- Latency:
  - Request sampled at edge N gives mem_req high after edge N.
  - mem_ack in cycle M gives the owner's ack = 1 combinationally in cycle M, with rdata = mem_rdata.
  - Edge M+1 returns to IDLE and clears mem_req.
  - Minimum 2 cycles request to ack; back-to-back transfers are spaced by one IDLE cycle.
- BUSY_x: mem_* held stable until mem_ack. The non-owner's ack stays 0.
- d_we = 1 completion: d_ack pulses and d_rdata = 0.
- Requester deasserts req before ack (protocol violation): the transfer still completes and the ack still pulses.
- mem_ack while IDLE is ignored; no ack pulses.
- Reset asserted mid-transfer: all outputs clear immediately. The memory transfer is abandoned and requesters reissue after reset.
- stall is combinational from req/ack; stall = 0 during reset.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on grant and increments each BUSY cycle without mem_ack.
  - On reaching TIMEOUT_CYC the arbiter clears mem_req and pulses the owner's ack with bus_err = 1 and rdata = 0, then returns to IDLE.
  - mem_ack in the same cycle as the timeout wins: normal completion, bus_err = 0.
- Undefined: no counter; bus_err tied 0; BUSY waits indefinitely.

Test Plan:
- Reset: reset_n = 0 with i_req = 1 → mem_req = 0, i_ack = 0, stall = 0. Release reset → mem_req = 1, mem_addr = i_addr one cycle later.
- Single fetch: i_addr = 0x0000_0010, memory acks 3 cycles later with 0x0050_0093 → i_ack pulses 1 cycle, i_rdata = 0x0050_0093, mem_we = 0.
- Store: d_we = 1, d_be = 4'b0011, d_addr = 0x100, d_wdata = 0xDEAD_BEEF → mem_be = 0011, mem_wdata = 0xDEADBEEF. d_ack = 1 and d_rdata = 0 in the mem_ack cycle.
- Contention: i_req and d_req held high for 4 transfers from reset → grant order D, I, D, I; each ack goes only to its owner.
- Reset mid-transfer: pull reset_n low 2 cycles after a D grant → mem_req drops in the same cycle. After release, the still-pending d_req is regranted.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC = 8): mem_ack never asserted → after 8 BUSY cycles, i_ack = 1, bus_err = 1, rdata = 0, mem_req = 0. Without the macro, the arbiter is still busy at cycle 50.
